// File: rtl/osd_dem_uart_bb_fifo_pkg.sv
// Shared constants for the bus-bridge UART front end: register addresses,
// register bit positions and a small helper for deriving count widths.
package dem_uart_package;

  // Word addresses on the block bus
  localparam logic [3:0] ADDR_DATA       = 4'h0;
  localparam logic [3:0] ADDR_STATUS     = 4'h1;
  localparam logic [3:0] ADDR_CTRL       = 4'h2;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'h3;

  // DATA read layout
  localparam int DATA_VALID_BIT = 8;

  // STATUS layout
  localparam int STATUS_TX_FULL      = 12;
  localparam int STATUS_RX_EMPTY     = 13;
  localparam int STATUS_RX_COUNT_LSB = 16;

  // CTRL layout
  localparam int CTRL_IRQ_EN_LSB = 8;
  localparam int CTRL_IRQ_EN_MSB = 10;
  localparam int CTRL_FLUSH_TX   = 16;
  localparam int CTRL_FLUSH_RX   = 17;

  // IRQ_STATUS / irq_en bit indices
  localparam int IRQ_RX_LEVEL = 0;
  localparam int IRQ_TX_EMPTY = 1;
  localparam int IRQ_TX_OVF   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/osd_dem_uart_bb_fifo_if.sv
// Single-cycle block bus between the CPU side and the UART front end.
//   bb_addr_i : word register address
//   bb_din_i  : write data
//   bb_en_i   : access strobe, one access per cycle
//   bb_we_i   : 1 = write, 0 = read
//   bb_dout_o : registered read data
// master = CPU side, slave = UART front end.
interface osd_dem_uart_bb_fifo_if #(
  parameter int DW = 32
);
  logic [3:0]    bb_addr_i;
  logic [DW-1:0] bb_din_i;
  logic          bb_en_i;
  logic          bb_we_i;
  logic [DW-1:0] bb_dout_o;

  modport master (
    output bb_addr_i, bb_din_i, bb_en_i, bb_we_i,
    input  bb_dout_o
  );

  modport slave (
    input  bb_addr_i, bb_din_i, bb_en_i, bb_we_i,
    output bb_dout_o
  );
endinterface

// File: rtl/osd_dem_uart_fifo.sv
// Show-ahead synchronous FIFO used for both the TX and RX byte queues.
//   clk, rst : clock, synchronous active-low reset
//   push     : write din (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   flush    : empty the FIFO on the next edge; overrides push/pop
//   din      : write data
//   dout     : current head entry (valid while !empty)
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
module osd_dem_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Gating uses the registered count, so a push into a full FIFO is
  // rejected even if a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/osd_dem_uart_bb_fifo.sv
// Bus-bridge UART front end: CPU-side register set (DATA, STATUS, CTRL,
// IRQ_STATUS) over TX/RX byte FIFOs feeding the emulated UART character
// stream.
//   clk, rst   : clock, synchronous active-low reset
//   bb         : block bus slave (address, write data, strobe, we, read data)
//   out_valid  : TX byte available (suppressed while drop)
//   out_char   : TX FIFO head
//   out_ready  : emulator accepts the TX byte
//   in_valid   : RX byte offered by the emulator
//   in_char    : RX byte
//   in_ready   : RX FIFO can accept
//   drop       : host detached; TX bytes are drained and discarded
//   irq        : registered level interrupt
module osd_dem_uart_bb_fifo
  import dem_uart_package::*;
#(
  parameter int DW       = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  osd_dem_uart_bb_fifo_if.slave    bb,
  output logic                     out_valid,
  output logic [7:0]               out_char,
  input  logic                     out_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_char,
  output logic                     in_ready,
  input  logic                     drop,
  output logic                     irq
);

  localparam int CW  = $clog2(max_int(TX_DEPTH, RX_DEPTH)) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]     rx_dout;

  logic [CW-1:0]  rx_thresh;
  logic [2:0]     irq_en;
  logic           tx_ovf;
  logic           alive;

  logic           wr, rd;
  logic           wr_data, wr_ctrl, wr_irq, rd_data;
  logic           tx_push, tx_pop, tx_flush;
  logic           rx_push, rx_pop, rx_flush;
  logic           rx_level;
  logic [2:0]     irq_stat;
  logic [DW-1:0]  rdata;
  logic           unused_din;

  assign unused_din = ^bb.bb_din_i;

  assign wr      = bb.bb_en_i && bb.bb_we_i;
  assign rd      = bb.bb_en_i && !bb.bb_we_i;
  assign wr_data = wr && (bb.bb_addr_i == ADDR_DATA);
  assign wr_ctrl = wr && (bb.bb_addr_i == ADDR_CTRL);
  assign wr_irq  = wr && (bb.bb_addr_i == ADDR_IRQ_STATUS);
  assign rd_data = rd && (bb.bb_addr_i == ADDR_DATA);

  assign tx_push  = wr_data;
  // While dropped, the head is drained every cycle regardless of out_ready.
  assign tx_pop   = !tx_empty && (drop || out_ready);
  assign tx_flush = wr_ctrl && bb.bb_din_i[CTRL_FLUSH_TX];

  assign rx_push  = in_valid && in_ready;
  assign rx_pop   = rd_data;
  assign rx_flush = wr_ctrl && bb.bb_din_i[CTRL_FLUSH_RX];

  assign out_valid = !tx_empty && !drop;
  // alive keeps in_ready low until the first edge out of reset.
  assign in_ready  = rst && alive && !rx_full;

  osd_dem_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (bb.bb_din_i[7:0]),
    .dout  (out_char),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  osd_dem_uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (in_char),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_level = (CW'(rx_count) >= rx_thresh);

  always_comb begin
    irq_stat               = '0;
    irq_stat[IRQ_RX_LEVEL] = rx_level;
    irq_stat[IRQ_TX_EMPTY] = tx_empty;
    irq_stat[IRQ_TX_OVF]   = tx_ovf;
  end

  always_comb begin
    rdata = '0;
    case (bb.bb_addr_i)
      ADDR_DATA: begin
        if (!rx_empty) begin
          rdata[7:0]            = rx_dout;
          rdata[DATA_VALID_BIT] = 1'b1;
        end
      end
      ADDR_STATUS: begin
        rdata[CW-1:0]                         = CW'(tx_count);
        rdata[STATUS_RX_COUNT_LSB +: CW]      = CW'(rx_count);
        rdata[STATUS_TX_FULL]                 = tx_full;
        rdata[STATUS_RX_EMPTY]                = rx_empty;
      end
      ADDR_CTRL: begin
        rdata[CW-1:0]                         = rx_thresh;
        rdata[CTRL_IRQ_EN_MSB:CTRL_IRQ_EN_LSB] = irq_en;
      end
      ADDR_IRQ_STATUS: begin
        rdata[2:0] = irq_stat;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_thresh    <= CW'(1);
      irq_en       <= '0;
      tx_ovf       <= 1'b0;
      alive        <= 1'b0;
      irq          <= 1'b0;
      bb.bb_dout_o <= '0;
    end else begin
      alive <= 1'b1;
      if (wr_ctrl) begin
        rx_thresh <= bb.bb_din_i[CW-1:0];
        irq_en    <= bb.bb_din_i[CTRL_IRQ_EN_MSB:CTRL_IRQ_EN_LSB];
      end
      // A new overflow beats a write-1-to-clear on the same edge.
      if (wr_data && tx_full)
        tx_ovf <= 1'b1;
      else if (wr_irq && bb.bb_din_i[IRQ_TX_OVF])
        tx_ovf <= 1'b0;
      irq <= |(irq_stat & irq_en);
      if (rd) bb.bb_dout_o <= rdata;
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_bb_fifo.sv
module tb_osd_dem_uart_bb_fifo;
  localparam int DW  = 32;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       out_valid, in_ready, irq;
  logic [7:0] out_char;
  logic       out_ready = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_char   = 8'h00;
  logic       drop      = 1'b0;

  int checks = 0;
  int errors = 0;

  osd_dem_uart_bb_fifo_if #(.DW(DW)) bb_if ();

  osd_dem_uart_bb_fifo #(.DW(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bb        (bb_if),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .drop      (drop),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: queues plus the few register values
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  bit          m_ovf    = 0;
  bit          m_alive  = 0;
  int          m_thresh = 1;
  logic [2:0]  m_irq_en = 3'b000;
  logic [31:0] m_dout   = 32'h0;
  logic        m_irq    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic en, input logic we, input logic [3:0] a, input logic [31:0] d);
    bb_if.bb_en_i   = en;
    bb_if.bb_we_i   = we;
    bb_if.bb_addr_i = a;
    bb_if.bb_din_i  = d;
  endtask

  task automatic model_edge();
    int tsz = tx_q.size();
    int rsz = rx_q.size();
    bit rdy = rst && m_alive && (rsz < RXD);
    bit wr  = bb_if.bb_en_i && bb_if.bb_we_i;
    bit rd  = bb_if.bb_en_i && !bb_if.bb_we_i;
    logic [3:0]  a = bb_if.bb_addr_i;
    logic [31:0] d = bb_if.bb_din_i;
    if (!rst) begin
      tx_q.delete(); rx_q.delete();
      m_ovf = 0; m_alive = 0; m_thresh = 1; m_irq_en = 0; m_dout = 0; m_irq = 0;
      return;
    end
    m_irq = (m_ovf && m_irq_en[2]) || ((tsz == 0) && m_irq_en[1]) ||
            ((rsz >= m_thresh) && m_irq_en[0]);
    if (rd) begin
      case (a)
        4'h0: m_dout = (rsz > 0) ? {23'b0, 1'b1, rx_q[0]} : 32'h0;
        4'h1: m_dout = 32'(tsz) | (32'(rsz) << 16) | ((tsz == TXD) ? 32'h1000 : 32'h0) |
                       ((rsz == 0) ? 32'h2000 : 32'h0);
        4'h2: m_dout = 32'(m_thresh) | (32'(m_irq_en) << 8);
        4'h3: m_dout = {29'b0, m_ovf, (tsz == 0), (rsz >= m_thresh)};
        default: m_dout = 32'h0;
      endcase
    end
    if (wr && a == 4'h0 && tsz == TXD) m_ovf = 1;
    else if (wr && a == 4'h3 && d[2]) m_ovf = 0;
    if (wr && a == 4'h0 && tsz < TXD) tx_q.push_back(d[7:0]);
    if (tsz > 0 && (drop || out_ready)) void'(tx_q.pop_front());
    if (in_valid && rdy) rx_q.push_back(in_char);
    if (rd && a == 4'h0 && rsz > 0) void'(rx_q.pop_front());
    if (wr && a == 4'h2) begin
      m_thresh = int'(d[2:0]);
      m_irq_en = d[10:8];
      if (d[16]) tx_q.delete();
      if (d[17]) rx_q.delete();
    end
    m_alive = 1;
  endtask

  // One clock cycle: check combinational outputs, advance, check registers
  task automatic step();
    bit exp_ov;
    #1;
    exp_ov = (tx_q.size() > 0) && !drop;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("out_char", 32'(out_char), 32'(tx_q[0]));
    check("in_ready", 32'(in_ready), 32'(rst && m_alive && (rx_q.size() < RXD)));
    @(posedge clk);
    model_edge();
    #1;
    check("bb_dout", bb_if.bb_dout_o, m_dout);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  initial begin
    bus(0, 0, 4'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(); step();
    rst = 1'b1;
    step(); step();
    check("in_ready_idle", 32'(in_ready), 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    bus(1, 0, 4'h1, 32'h0); step(); bus(0, 0, 4'h0, 32'h0);
    check("status_reset", bb_if.bb_dout_o, 32'h2000);
    bus(1, 0, 4'h2, 32'h0); step(); bus(0, 0, 4'h0, 32'h0);
    check("ctrl_reset", bb_if.bb_dout_o, 32'h1);

    // TX two bytes streamed out
    out_ready = 1'b1;
    bus(1, 1, 4'h0, 32'h41); step();
    check("tx_first", 32'(out_char), 32'h41);
    bus(1, 1, 4'h0, 32'h42); step();
    check("tx_second", 32'(out_char), 32'h42);
    bus(0, 0, 4'h0, 32'h0); step();
    bus(1, 0, 4'h1, 32'h0); step(); bus(0, 0, 4'h0, 32'h0);
    check("tx_drained", bb_if.bb_dout_o, 32'h2000);

    // TX overflow and irq
    out_ready = 1'b0;
    bus(1, 1, 4'h2, 32'h401); step();
    for (int i = 0; i < 5; i++) begin
      bus(1, 1, 4'h0, 32'h50 + 32'(i)); step();
    end
    bus(1, 0, 4'h1, 32'h0); step();
    check("tx_full_status", bb_if.bb_dout_o, 32'h3004);
    check("irq_ovf", 32'(irq), 32'h1);
    bus(1, 1, 4'h3, 32'h4); step();
    bus(0, 0, 4'h0, 32'h0); step();
    check("irq_ovf_clr", 32'(irq), 32'h0);
    check("tx_head_kept", 32'(out_char), 32'h50);
    bus(1, 1, 4'h2, 32'h10001); step();
    bus(0, 0, 4'h0, 32'h0); step();

    // RX threshold interrupt and reads
    bus(1, 1, 4'h2, 32'h103); step();
    bus(0, 0, 4'h0, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_char = 8'h10 + 8'(i); step();
    end
    in_valid = 1'b0;
    step();
    check("irq_rx_level", 32'(irq), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus(1, 0, 4'h0, 32'h0); step();
      check("rx_read", bb_if.bb_dout_o, (i < 3) ? (32'h110 + 32'(i)) : 32'h0);
      if (i == 1) check("irq_rx_fall", 32'(irq), 32'h0);
    end
    bus(0, 0, 4'h0, 32'h0);

    // RX fill: the byte beyond depth is held, then accepted after a read
    in_valid = 1'b1;
    for (int i = 0; i < RXD; i++) begin
      in_char = 8'($urandom); step();
    end
    check("rx_full_ready", 32'(in_ready), 32'h0);
    in_char = 8'hA5;
    step(); step();
    bus(1, 0, 4'h0, 32'h0); step();
    bus(0, 0, 4'h0, 32'h0); step();
    in_valid = 1'b0;
    for (int i = 0; i < RXD; i++) begin
      bus(1, 0, 4'h0, 32'h0); step();
    end
    check("rx_held_byte", bb_if.bb_dout_o, 32'h1A5);
    step();
    check("rx_after_empty", bb_if.bb_dout_o, 32'h0);
    bus(0, 0, 4'h0, 32'h0);

    // drop drains TX silently
    for (int i = 0; i < 3; i++) begin
      bus(1, 1, 4'h0, 32'(8'($urandom))); step();
    end
    bus(0, 0, 4'h0, 32'h0);
    drop = 1'b1;
    step(); step(); step();
    bus(1, 0, 4'h1, 32'h0); step(); bus(0, 0, 4'h0, 32'h0);
    check("drop_drained", bb_if.bb_dout_o, 32'h2000);
    drop = 1'b0;

    // RX flush while bytes are arriving
    in_valid = 1'b1; in_char = 8'h33;
    step(); step();
    bus(1, 1, 4'h2, 32'h20001); step();
    in_valid = 1'b0;
    bus(1, 0, 4'h1, 32'h0); step(); bus(0, 0, 4'h0, 32'h0);
    check("rx_flushed", bb_if.bb_dout_o, 32'h2000);

    // Randomized traffic against the model, including occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) != 0) d[17:16] = 2'b00;
      rst = ($urandom_range(0, 63) != 0);
      bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), d);
      in_valid  = 1'($urandom_range(0, 1));
      in_char   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      drop      = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b1;
    bus(0, 0, 4'h0, 32'h0);
    in_valid = 1'b0; drop = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
